// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types and helpers for the BRAM port arbiter.
//   Contents:
//     arb_state_t : arbitration state (no owner / DMA burst owner)
//     is_read()   : a request with all byte enables low is a read
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_LOCK1 = 1'b1
    } arb_state_t;

    function automatic logic is_read(input logic [3:0] we);
        return (we == 4'b0000);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin pick with a pointer register.
//   Ports:
//     clk, reset : clock, synchronous active-high reset (pointer -> 0)
//     req[1:0]   : request per port
//     update     : when high and a grant is issued, pointer <= ~winner
//     gnt[1:0]   : one-hot (or zero) combinational grant
//   With both ports requesting, the port named by the pointer wins.
// ----------------------------------------------------------------------------
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (update && (gnt != 2'b00)) begin
            ptr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port synchronous BRAM (1-cycle read latency) between
//   the core data port (0) and a DMA/bootloader engine (1). Round-robin
//   arbitration; port 1 may hold the BRAM for a bounded burst via lock1.
//   Ports:
//     clk, reset                          : clock, sync active-high reset
//     req0/we0/adr0/wdata0                : core request
//     gnt0/rvalid0/rdata0/core_stall      : core response, stall = req0&~gnt0
//     req1/we1/adr1/wdata1/lock1          : DMA request, lock1 = burst wish
//     gnt1/rvalid1/rdata1                 : DMA response
//     mem_en/mem_we/mem_addr/mem_wdata    : BRAM command (zero when idle)
//     mem_rdata                           : BRAM read data (cycle after read)
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int ADDR_W    = 14,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [3:0]        we0,
    input  logic [XLEN-1:0]   adr0,
    input  logic [XLEN-1:0]   wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [XLEN-1:0]   rdata0,
    output logic              core_stall,
    input  logic              req1,
    input  logic [3:0]        we1,
    input  logic [XLEN-1:0]   adr1,
    input  logic [XLEN-1:0]   wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [XLEN-1:0]   rdata1,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state;
    logic [CNT_W-1:0] burst_cnt;
    logic [1:0]       arb_req;
    logic [1:0]       arb_gnt;
    logic             arb_update;
    logic             lock_gnt;
    logic             rsp_pending;
    logic             rsp_owner;

    // Byte offset and upper address bits are not used by this block.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{adr0[XLEN-1:ADDR_W+2], adr0[1:0],
                               adr1[XLEN-1:ADDR_W+2], adr1[1:0]};

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (arb_req),
        .update (arb_update),
        .gnt    (arb_gnt)
    );

    // While locked the DMA is granted directly and the round-robin pointer
    // is frozen. A release (req1/lock1 low) hands the same cycle back to the
    // normal round-robin pick; a forced release offers the arbiter only
    // port 0, which also leaves the pointer at 1.
    always_comb begin
        arb_req    = '0;
        arb_update = 1'b0;
        lock_gnt   = 1'b0;
        if (!reset) begin
            case (state)
                ST_ARB: begin
                    arb_req    = {req1, req0};
                    arb_update = 1'b1;
                end
                ST_LOCK1: begin
                    if (!req1 || !lock1) begin
                        arb_req    = {req1, req0};
                        arb_update = 1'b1;
                    end else if ((burst_cnt == CNT_MAX) && req0) begin
                        arb_req    = 2'b01;
                        arb_update = 1'b1;
                    end else begin
                        lock_gnt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt0       = arb_gnt[0];
    assign gnt1       = arb_gnt[1] | lock_gnt;
    assign core_stall = req0 & ~gnt0;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_en    = 1'b1;
            mem_we    = we0;
            mem_addr  = adr0[ADDR_W+1:2];
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = adr1[ADDR_W+1:2];
            mem_wdata = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ARB;
            burst_cnt <= '0;
        end else if (lock_gnt) begin
            state <= ST_LOCK1;
            if (burst_cnt != CNT_MAX) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end else if (arb_gnt[1] && lock1) begin
            state     <= ST_LOCK1;
            burst_cnt <= CNT_W'(1);
        end else begin
            state     <= ST_ARB;
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pending <= 1'b0;
            rsp_owner   <= 1'b0;
        end else begin
            rsp_pending <= (gnt0 && is_read(we0)) || (gnt1 && is_read(we1));
            rsp_owner   <= gnt1;
        end
    end

    // Reset drops an in-flight read in the cycle it is asserted.
    assign rvalid0 = rsp_pending & ~rsp_owner & ~reset;
    assign rvalid1 = rsp_pending &  rsp_owner & ~reset;
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench with a behavioural arbitration model and a BRAM model
//   whose read data is a fixed function of the word address.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int XLEN      = 32;
    localparam int ADDR_W    = 14;
    localparam int MAX_BURST = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
    logic [3:0]        we0 = '0, we1 = '0;
    logic [XLEN-1:0]   adr0 = '0, adr1 = '0, wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, core_stall, mem_en;
    logic [XLEN-1:0]   rdata0, rdata1, mem_wdata;
    logic [XLEN-1:0]   mem_rdata = '0;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .core_stall(core_stall),
        .req1(req1), .we1(we1), .adr1(adr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [13:0] a);
        return {2'b10, a, ~a, 2'b01};
    endfunction

    // BRAM: read data is a pure function of the address read last cycle.
    always @(posedge clk) begin
        if (mem_en && mem_we == 4'b0000) mem_rdata <= pattern(mem_addr);
        else mem_rdata <= $urandom;
    end

    // Model state: lock ownership, beats taken, turn pointer, pending read.
    bit          m_locked = 1'b0;
    int          m_cnt = 0;
    int          m_ptr = 0;
    bit          m_pend = 1'b0;
    int          m_owner = 0;
    logic [13:0] m_paddr = '0;

    function automatic int model_winner();
        if (reset) return -1;
        if (m_locked && req1 && lock1) begin
            if (m_cnt >= MAX_BURST && req0) return 0;
            return 1;
        end
        if (req0 && req1) return m_ptr;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    initial forever begin
        int w;
        bit cont;
        logic [31:0] a;
        @(posedge clk);
        w = model_winner();
        if (reset) begin
            m_locked = 0; m_cnt = 0; m_ptr = 0; m_pend = 0;
        end else begin
            cont = m_locked && req1 && lock1 && (w == 1);
            if (cont) begin
                if (m_cnt < MAX_BURST) m_cnt = m_cnt + 1;
            end else begin
                if (w >= 0) m_ptr = 1 - w;
                if (w == 1 && lock1) begin m_locked = 1; m_cnt = 1; end
                else begin m_locked = 0; m_cnt = 0; end
            end
            m_pend  = (w == 0 && we0 == 4'b0) || (w == 1 && we1 == 4'b0);
            m_owner = w;
            a = (w == 1) ? adr1 : adr0;
            m_paddr = a[15:2];
        end
    end

    // Per-cycle comparison, mid low phase after inputs have settled.
    initial forever begin
        int w;
        logic [31:0] ea, ed;
        logic [3:0] ew;
        @(negedge clk);
        #2;
        if (checking) begin
            w = model_winner();
            ea = (w == 1) ? adr1 : adr0;
            ew = (w == 0) ? we0 : (w == 1) ? we1 : 4'b0;
            ed = (w == 0) ? wdata0 : (w == 1) ? wdata1 : 32'h0;
            check("gnt0", 32'(gnt0), 32'(w == 0));
            check("gnt1", 32'(gnt1), 32'(w == 1));
            check("core_stall", 32'(core_stall), 32'(req0 && w != 0));
            check("mem_en", 32'(mem_en), 32'(w >= 0));
            check("mem_we", 32'(mem_we), 32'(ew));
            check("mem_addr", 32'(mem_addr), (w >= 0) ? 32'(ea[15:2]) : 32'h0);
            check("mem_wdata", mem_wdata, ed);
            check("rvalid0", 32'(rvalid0), 32'(!reset && m_pend && m_owner == 0));
            check("rvalid1", 32'(rvalid1), 32'(!reset && m_pend && m_owner == 1));
            check("rdata0", rdata0, (!reset && m_pend && m_owner == 0) ? pattern(m_paddr) : 32'h0);
            check("rdata1", rdata1, (!reset && m_pend && m_owner == 1) ? pattern(m_paddr) : 32'h0);
        end
    end

    task automatic apply(input logic r0, input logic [3:0] w0, input logic [31:0] a0,
                         input logic r1, input logic [3:0] w1, input logic [31:0] a1,
                         input logic [31:0] d1, input logic l1);
        @(negedge clk);
        req0 = r0; we0 = w0; adr0 = a0; wdata0 = 32'h1234_5678;
        req1 = r1; we1 = w1; adr1 = a1; wdata1 = d1; lock1 = l1;
    endtask

    task automatic idle();
        apply(1'b0, 4'b0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 0; req1 = 0; lock1 = 0; we0 = '0; we1 = '0;
        @(negedge clk);
        checking = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0]  seq, stl;
        logic [12:0] g0;
        int n1;

        do_reset();
        #3;
        check("reset_gnt0", 32'(gnt0), 32'h0);
        check("reset_mem_en", 32'(mem_en), 32'h0);

        // Core-only read.
        apply(1, 4'b0, 32'h4000_0010, 0, 4'b0, 32'h0, 32'h0, 0);
        #3;
        check("core_gnt0", 32'(gnt0), 32'h1);
        check("core_addr", 32'(mem_addr), 32'h004);
        check("core_stall0", 32'(core_stall), 32'h0);
        idle();
        #3;
        check("core_rvalid0", 32'(rvalid0), 32'h1);
        check("core_rdata0", rdata0, pattern(14'h004));

        // Both reading, no lock: strict alternation starting with the core.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1, 4'b0, 32'h100 + 32'(4 * i), 1, 4'b0, 32'h2000 + 32'(4 * i), 32'h0, 0);
            #3;
            seq[i] = gnt0;
            stl[i] = core_stall;
        end
        idle();
        check("alt_seq", 32'(seq), 32'h5);
        check("alt_stall", 32'(stl), 32'hA);

        // Locked DMA burst, core joins on the third cycle, DMA stops after 12.
        do_reset();
        n1 = 0;
        for (int i = 0; i < 13; i++) begin
            apply(i >= 2, 4'b0, 32'h300, i < 12, 4'b0, 32'h800 + 32'(4 * i), 32'h0, 1);
            #3;
            g0[i] = gnt0;
            if (gnt1) n1++;
            if (i == 2) check("lock_stall", 32'(core_stall), 32'h1);
        end
        idle();
        check("lock_gnt0_seq", 32'(g0), 32'h1100);
        check("lock_gnt1_count", 32'(n1), 32'd11);

        // DMA write: byte enables and data pass through, no read response.
        apply(0, 4'b0, 32'h0, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 0);
        #3;
        check("wr_gnt1", 32'(gnt1), 32'h1);
        check("wr_we", 32'(mem_we), 32'h3);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_addr", 32'(mem_addr), 32'h010);
        idle();
        #3;
        check("wr_no_rvalid1", 32'(rvalid1), 32'h0);

        // Reset the cycle after a granted read drops the response.
        do_reset();
        apply(1, 4'b0, 32'h8, 0, 4'b0, 32'h0, 32'h0, 0);
        @(negedge clk);
        reset = 1'b1; req0 = 1; req1 = 1; lock1 = 1;
        #3;
        check("rst_rvalid0", 32'(rvalid0), 32'h0);
        check("rst_rvalid1", 32'(rvalid1), 32'h0);
        check("rst_gnt1", 32'(gnt1), 32'h0);
        @(negedge clk);
        reset = 1'b0; lock1 = 0; adr1 = 32'h44;
        #3;
        check("post_rst_gnt0", 32'(gnt0), 32'h1);
        check("post_rst_gnt1", 32'(gnt1), 32'h0);
        idle();
        repeat (3) @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, limit 100000");
        $fatal(1);
    end

endmodule
